// File: rtl/control_sequencer.sv
// Microcode sequencer for the 8-bit processor: six-state T-cycle ring plus HALT,
// decoding the IR opcode into load/enable strobes for every bus-attached block.
module control_sequencer #(
    parameter logic [3:0] OP_LDA = 4'h0,
    parameter logic [3:0] OP_ADD = 4'h1,
    parameter logic [3:0] OP_SUB = 4'h2,
    parameter logic [3:0] OP_OUT = 4'hE,
    parameter logic [3:0] OP_HLT = 4'hF
) (
    input  logic       clk,
    input  logic       clr,
    input  logic       run,
    input  logic [3:0] opcode,
    output logic [2:0] t_state,
    output logic       halted,
    output logic       pc_en,
    output logic       pc_inc,
    output logic       mar_load,
    output logic       ram_en,
    output logic       ir_load,
    output logic       ir_en,
    output logic       a_load,
    output logic       a_en,
    output logic       b_load,
    output logic       alu_en,
    output logic       alu_sub,
    output logic       out_load
);

    localparam int unsigned STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        ST_T1   = 3'd0,
        ST_T2   = 3'd1,
        ST_T3   = 3'd2,
        ST_T4   = 3'd3,
        ST_T5   = 3'd4,
        ST_T6   = 3'd5,
        ST_HALT = 3'd7
    } state_t;

    state_t state_q, state_d;
    logic   halted_q, halted_d;

    logic is_lda, is_add, is_sub, is_out, is_arith;

    always_comb begin
        is_lda   = (opcode == OP_LDA);
        is_add   = (opcode == OP_ADD);
        is_sub   = (opcode == OP_SUB);
        is_out   = (opcode == OP_OUT);
        is_arith = is_add | is_sub;
    end

    // Next-state: ring advances only while run is high; HALT is absorbing.
    always_comb begin
        state_d  = state_q;
        halted_d = halted_q;
        if (run) begin
            case (state_q)
                ST_T1:   state_d = ST_T2;
                ST_T2:   state_d = ST_T3;
                ST_T3:   state_d = ST_T4;
                ST_T4:   state_d = (opcode == OP_HLT) ? ST_HALT : ST_T5;
                ST_T5:   state_d = ST_T6;
                ST_T6:   state_d = ST_T1;
                ST_HALT: state_d = ST_HALT;
                default: state_d = ST_T1;
            endcase
        end
        halted_d = (state_d == ST_HALT);
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            state_q  <= ST_T1;
            halted_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            halted_q <= halted_d;
        end
    end

    // Strobes decode from the registered state (and IR opcode in T4-T6), gated by run.
    always_comb begin
        pc_en    = 1'b0;
        pc_inc   = 1'b0;
        mar_load = 1'b0;
        ram_en   = 1'b0;
        ir_load  = 1'b0;
        ir_en    = 1'b0;
        a_load   = 1'b0;
        a_en     = 1'b0;
        b_load   = 1'b0;
        alu_en   = 1'b0;
        alu_sub  = 1'b0;
        out_load = 1'b0;
        if (run) begin
            case (state_q)
                ST_T1: begin
                    pc_en    = 1'b1;
                    mar_load = 1'b1;
                end
                ST_T2: begin
                    pc_inc = 1'b1;
                end
                ST_T3: begin
                    ram_en  = 1'b1;
                    ir_load = 1'b1;
                end
                ST_T4: begin
                    if (is_lda || is_arith) begin
                        ir_en    = 1'b1;
                        mar_load = 1'b1;
                    end else if (is_out) begin
                        a_en     = 1'b1;
                        out_load = 1'b1;
                    end
                end
                ST_T5: begin
                    if (is_lda) begin
                        ram_en = 1'b1;
                        a_load = 1'b1;
                    end else if (is_arith) begin
                        ram_en = 1'b1;
                        b_load = 1'b1;
                    end
                end
                ST_T6: begin
                    if (is_arith) begin
                        alu_en  = 1'b1;
                        a_load  = 1'b1;
                        alu_sub = is_sub;
                    end
                end
                default: ;
            endcase
        end
    end

    assign t_state = STATE_W'(state_q);
    assign halted  = halted_q;

endmodule

// File: tb/tb_control_sequencer.sv
// Directed bench for control_sequencer: each step queues its expected outputs
// and the comparison pops them once the DUT outputs for that cycle have settled.
module tb_control_sequencer;

    logic       clk = 1'b0;
    logic       clr;
    logic       run;
    logic [3:0] opcode;
    logic [2:0] t_state;
    logic       halted;
    logic       pc_en, pc_inc, mar_load, ram_en, ir_load, ir_en;
    logic       a_load, a_en, b_load, alu_en, alu_sub, out_load;

    control_sequencer dut (
        .clk      (clk),
        .clr      (clr),
        .run      (run),
        .opcode   (opcode),
        .t_state  (t_state),
        .halted   (halted),
        .pc_en    (pc_en),
        .pc_inc   (pc_inc),
        .mar_load (mar_load),
        .ram_en   (ram_en),
        .ir_load  (ir_load),
        .ir_en    (ir_en),
        .a_load   (a_load),
        .a_en     (a_en),
        .b_load   (b_load),
        .alu_en   (alu_en),
        .alu_sub  (alu_sub),
        .out_load (out_load)
    );

    always #5 clk = ~clk;

    localparam logic [11:0] S_NONE = 12'h000;
    localparam logic [11:0] S_PCE  = 12'h800;
    localparam logic [11:0] S_PCI  = 12'h400;
    localparam logic [11:0] S_MAR  = 12'h200;
    localparam logic [11:0] S_RAM  = 12'h100;
    localparam logic [11:0] S_IRL  = 12'h080;
    localparam logic [11:0] S_IRE  = 12'h040;
    localparam logic [11:0] S_AL   = 12'h020;
    localparam logic [11:0] S_AE   = 12'h010;
    localparam logic [11:0] S_BL   = 12'h008;
    localparam logic [11:0] S_ALUE = 12'h004;
    localparam logic [11:0] S_SUB  = 12'h002;
    localparam logic [11:0] S_OUT  = 12'h001;

    typedef struct packed {
        logic [2:0]  t;
        logic        h;
        logic [11:0] s;
    } exp_t;

    exp_t  exp_q[$];
    string tag_q[$];
    int    n_cmp = 0;
    int    n_mis = 0;

    logic [11:0] strobes;
    logic [4:0]  bus_drv;
    assign strobes = {pc_en, pc_inc, mar_load, ram_en, ir_load, ir_en,
                      a_load, a_en, b_load, alu_en, alu_sub, out_load};
    assign bus_drv = {pc_en, ram_en, ir_en, a_en, alu_en};

    // One clock cycle: drive inputs, queue expectation, check settled outputs, advance.
    task automatic cyc(input logic r, input logic c, input logic [3:0] op, input string tag,
                       input logic [2:0] t, input logic h, input logic [11:0] s);
        exp_t  e;
        exp_t  got;
        string tg;
        logic  bus_ok;
        run    = r;
        clr    = c;
        opcode = op;
        e      = {t, h, s};
        exp_q.push_back(e);
        tag_q.push_back(tag);
        #2;
        e   = exp_q.pop_front();
        tg  = tag_q.pop_front();
        got = {t_state, halted, strobes};
        n_cmp++;
        assert (got === e) else begin
            n_mis++;
            $error("FAIL %s: observed t=%0d halted=%b strobes=%03h expected t=%0d halted=%b strobes=%03h",
                   tg, got.t, got.h, got.s, e.t, e.h, e.s);
        end
        bus_ok = ($countones(bus_drv) <= 1);
        n_cmp++;
        assert (bus_ok === 1'b1) else begin
            n_mis++;
            $error("FAIL %s bus: observed drivers=%05b expected at most one high", tg, bus_drv);
        end
        @(posedge clk);
        #1;
    endtask

    // Fetch with the previous instruction still in the IR: opcode must not matter here.
    task automatic fetch(input logic [3:0] prev_op, input string tag);
        cyc(1'b1, 1'b0, prev_op, {tag, "_t1"}, 3'd0, 1'b0, S_PCE | S_MAR);
        cyc(1'b1, 1'b0, prev_op, {tag, "_t2"}, 3'd1, 1'b0, S_PCI);
        cyc(1'b1, 1'b0, prev_op, {tag, "_t3"}, 3'd2, 1'b0, S_RAM | S_IRL);
    endtask

    task automatic exec(input logic [3:0] op, input string tag,
                        input logic [11:0] s4, input logic [11:0] s5, input logic [11:0] s6);
        cyc(1'b1, 1'b0, op, {tag, "_t4"}, 3'd3, 1'b0, s4);
        cyc(1'b1, 1'b0, op, {tag, "_t5"}, 3'd4, 1'b0, s5);
        cyc(1'b1, 1'b0, op, {tag, "_t6"}, 3'd5, 1'b0, s6);
    endtask

    initial begin
        clr    = 1'b1;
        run    = 1'b1;
        opcode = 4'hF;
        @(posedge clk);
        #1;

        // LDA, fetched while the IR still holds HLT
        fetch(4'hF, "lda");
        exec(4'h0, "lda", S_IRE | S_MAR, S_RAM | S_AL, S_NONE);
        // ADD, SUB
        fetch(4'h0, "add");
        exec(4'h1, "add", S_IRE | S_MAR, S_RAM | S_BL, S_ALUE | S_AL);
        fetch(4'h1, "sub");
        exec(4'h2, "sub", S_IRE | S_MAR, S_RAM | S_BL, S_ALUE | S_AL | S_SUB);
        // OUT and undefined opcode
        fetch(4'h2, "out");
        exec(4'hE, "out", S_AE | S_OUT, S_NONE, S_NONE);
        fetch(4'hE, "nop7");
        exec(4'h7, "nop7", S_NONE, S_NONE, S_NONE);

        // run gating in T3, then clear mid-instruction in T5
        cyc(1'b1, 1'b0, 4'h7, "gate_t1", 3'd0, 1'b0, S_PCE | S_MAR);
        cyc(1'b1, 1'b0, 4'h7, "gate_t2", 3'd1, 1'b0, S_PCI);
        for (int i = 0; i < 3; i++)
            cyc(1'b0, 1'b0, 4'h7, "gate_hold", 3'd2, 1'b0, S_NONE);
        cyc(1'b1, 1'b0, 4'h7, "gate_t3", 3'd2, 1'b0, S_RAM | S_IRL);
        cyc(1'b1, 1'b0, 4'h0, "gate_t4", 3'd3, 1'b0, S_IRE | S_MAR);
        cyc(1'b1, 1'b1, 4'h0, "clr_in_t5", 3'd4, 1'b0, S_RAM | S_AL);
        cyc(1'b1, 1'b0, 4'h0, "after_clr", 3'd0, 1'b0, S_PCE | S_MAR);
        cyc(1'b1, 1'b0, 4'h0, "after_clr_t2", 3'd1, 1'b0, S_PCI);
        cyc(1'b1, 1'b0, 4'h0, "after_clr_t3", 3'd2, 1'b0, S_RAM | S_IRL);
        exec(4'h0, "lda2", S_IRE | S_MAR, S_RAM | S_AL, S_NONE);

        // HLT: T4 silent, then absorbing HALT regardless of run
        fetch(4'h0, "hlt");
        cyc(1'b1, 1'b0, 4'hF, "hlt_t4", 3'd3, 1'b0, S_NONE);
        for (int i = 0; i < 22; i++)
            cyc((i % 5) != 3, 1'b0, 4'hF, "halt", 3'd7, 1'b1, S_NONE);
        cyc(1'b1, 1'b1, 4'hF, "halt_clr", 3'd7, 1'b1, S_NONE);
        cyc(1'b1, 1'b0, 4'hF, "post_halt", 3'd0, 1'b0, S_PCE | S_MAR);
        cyc(1'b0, 1'b0, 4'hF, "post_halt_run0", 3'd1, 1'b0, S_NONE);
        cyc(1'b1, 1'b0, 4'hF, "post_halt_resume", 3'd1, 1'b0, S_PCI);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
